// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus between mem_ctrl and its responder, plus the host UART
// byte streams and status flags that the responder exposes.
interface mem_io_responder_if;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halt;
  logic        tx_overflow;

  modport master (
    output mem_addr, mem_wr, mem_din, tx_ready, rx_data, rx_valid,
    input  mem_dout, io_buffer_full, tx_data, tx_valid, rx_ready, halt, tx_overflow
  );

  modport slave (
    input  mem_addr, mem_wr, mem_din, tx_ready, rx_data, rx_valid,
    output mem_dout, io_buffer_full, tx_data, tx_valid, rx_ready, halt, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory/IO responder: byte RAM with one-cycle registered read, plus memory-mapped
// TX/RX FIFOs, status byte and halt register at addr[17:16] == 2'b11.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  mem_io_responder_if.slave  bus
);

  localparam int TW = $clog2(TX_DEPTH);
  localparam int RW = $clog2(RX_DEPTH);
  localparam logic [TW:0] TX_FULL_CNT = TX_DEPTH[TW:0];
  localparam logic [TW:0] TX_NEAR_CNT = TX_FULL_CNT - (TW+1)'(2);
  localparam logic [RW:0] RX_FULL_CNT = RX_DEPTH[RW:0];

  // Data storage: never reset
  logic [7:0] ram    [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] tx_mem [0:TX_DEPTH-1];
  logic [7:0] rx_mem [0:RX_DEPTH-1];

  logic [7:0]      mem_dout_q, mem_dout_d;
  logic            io_buffer_full_q, io_buffer_full_d;
  logic            halt_q, halt_d;
  logic            tx_overflow_q, tx_overflow_d;
  logic [TW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TW:0]     tx_count_q, tx_count_d;
  logic [RW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RW:0]     rx_count_q, rx_count_d;

  logic                  io;
  logic [2:0]            off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  ram_we;
  logic                  tx_full, tx_req, tx_push, tx_pop;
  logic                  rx_nonempty, rx_push, rx_pop;

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr[31:18];

  always_comb begin
    io  = (bus.mem_addr[17:16] == 2'b11);
    off = bus.mem_addr[2:0];
    idx = bus.mem_addr[ADDR_WIDTH-1:0];

    ram_we = rdy && !io && bus.mem_wr;

    tx_full = (tx_count_q == TX_FULL_CNT);
    tx_pop  = rdy && bus.tx_ready && (tx_count_q != '0);
    tx_req  = rdy && io && bus.mem_wr && (off == 3'd0);
    // A host pop in the same cycle frees the slot, so a full FIFO still accepts
    tx_push = tx_req && (!tx_full || tx_pop);

    rx_nonempty = (rx_count_q != '0);
    rx_push     = rdy && bus.rx_valid && (rx_count_q != RX_FULL_CNT);
    rx_pop      = rdy && io && !bus.mem_wr && (off == 3'd0) && rx_nonempty;
  end

  always_comb begin
    mem_dout_d    = mem_dout_q;
    halt_d        = halt_q;
    tx_overflow_d = tx_overflow_q;

    tx_wptr_d  = tx_push ? tx_wptr_q + TW'(1) : tx_wptr_q;
    tx_rptr_d  = tx_pop  ? tx_rptr_q + TW'(1) : tx_rptr_q;
    tx_count_d = tx_count_q + (TW+1)'(tx_push) - (TW+1)'(tx_pop);

    rx_wptr_d  = rx_push ? rx_wptr_q + RW'(1) : rx_wptr_q;
    rx_rptr_d  = rx_pop  ? rx_rptr_q + RW'(1) : rx_rptr_q;
    rx_count_d = rx_count_q + (RW+1)'(rx_push) - (RW+1)'(rx_pop);

    // Threshold leaves two slots for a store already in flight when the flag rises
    io_buffer_full_d = (tx_count_d >= TX_NEAR_CNT);

    if (tx_req && tx_full && !tx_pop) begin
      tx_overflow_d = 1'b1;
    end

    if (rdy) begin
      if (!io) begin
        mem_dout_d = ram[idx];
      end else begin
        mem_dout_d = 8'h00;
        unique case (off)
          3'd0: begin
            if (!bus.mem_wr && rx_nonempty) mem_dout_d = rx_mem[rx_rptr_q];
          end
          3'd4: begin
            if (bus.mem_wr) halt_d = 1'b1;
            else            mem_dout_d = {6'b0, rx_nonempty, tx_full};
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we)  ram[idx]          <= bus.mem_din;
    if (tx_push) tx_mem[tx_wptr_q] <= bus.mem_din;
    if (rx_push) rx_mem[rx_wptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_dout_q       <= 8'h00;
      io_buffer_full_q <= 1'b0;
      halt_q           <= 1'b0;
      tx_overflow_q    <= 1'b0;
      tx_wptr_q        <= '0;
      tx_rptr_q        <= '0;
      tx_count_q       <= '0;
      rx_wptr_q        <= '0;
      rx_rptr_q        <= '0;
      rx_count_q       <= '0;
    end else begin
      mem_dout_q       <= mem_dout_d;
      io_buffer_full_q <= io_buffer_full_d;
      halt_q           <= halt_d;
      tx_overflow_q    <= tx_overflow_d;
      tx_wptr_q        <= tx_wptr_d;
      tx_rptr_q        <= tx_rptr_d;
      tx_count_q       <= tx_count_d;
      rx_wptr_q        <= rx_wptr_d;
      rx_rptr_q        <= rx_rptr_d;
      rx_count_q       <= rx_count_d;
    end
  end

  assign bus.mem_dout       = mem_dout_q;
  assign bus.io_buffer_full = io_buffer_full_q;
  assign bus.halt           = halt_q;
  assign bus.tx_overflow    = tx_overflow_q;
  assign bus.tx_data        = tx_mem[tx_rptr_q];
  assign bus.tx_valid       = (tx_count_q != '0);
  assign bus.rx_ready       = (rx_count_q != RX_FULL_CNT);

endmodule
